// File: rtl/div_if.sv
// div_if: operand/result bundle between the EX stage and the divider.
//
// Handshake: the EX stage raises start and holds it, together with
// signed_div/a/b, while a divide sits in EX. The divider samples the
// operands on the first start cycle and answers with stall, which stays high
// until the cycle in which valid strobes for exactly one cycle with the
// result on hilo_out. The divider never gives backpressure on the result:
// EX advances in the valid cycle. cancel aborts at any time and
// suppresses stall and valid in the same cycle.
interface div_if #(
   parameter int WIDTH = 32
) ();
   logic                 start;
   logic                 signed_div;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 cancel;
   logic                 stall;
   logic                 busy;
   logic                 valid;
   logic [2*WIDTH-1:0]   hilo_out;

   modport master (
      output start, signed_div, a, b, cancel,
      input  stall, busy, valid, hilo_out
   );

   modport slave (
      input  start, signed_div, a, b, cancel,
      output stall, busy, valid, hilo_out
   );
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for DIV/DIVU.
// Result is {remainder, quotient} for the HI/LO write path. Signed
// divides run on operand magnitudes and the signs are applied on the way
// into hilo_out. Divide-by-zero short-cuts straight to the result cycle.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       resetn,
   div_if.slave       bus,
   output logic [1:0] state_dbg
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]          state;
   logic [1:0]          state_nxt;
   logic [CW-1:0]       counter;
   logic [WIDTH-1:0]    rem;
   logic [WIDTH-1:0]    quo;
   logic [WIDTH-1:0]    dvsr;
   logic                qsign;
   logic                rsign;
   logic                valid_r;
   logic [2*WIDTH-1:0]  hilo_r;

   // operand capture helpers
   logic                a_neg;
   logic                b_neg;
   logic [WIDTH-1:0]    a_mag;
   logic [WIDTH-1:0]    b_mag;
   logic                div_zero;

   // one restoring iteration
   logic [WIDTH:0]      rem_sh;
   logic [WIDTH:0]      trial;
   logic                take;
   logic [WIDTH-1:0]    rem_nxt;
   logic [WIDTH-1:0]    quo_nxt;
   logic [WIDTH-1:0]    rem_fix;
   logic [WIDTH-1:0]    quo_fix;

   assign a_neg    = bus.signed_div & bus.a[WIDTH-1];
   assign b_neg    = bus.signed_div & bus.b[WIDTH-1];
   assign a_mag    = a_neg ? -bus.a : bus.a;
   assign b_mag    = b_neg ? -bus.b : bus.b;
   assign div_zero = (bus.b == '0);

   // Shift {rem, quo} left one place and try to subtract the divisor. When
   // the bit shifted out of rem is set the partial remainder already
   // exceeds any WIDTH-bit divisor, so the subtraction always succeeds.
   assign rem_sh  = {rem, quo[WIDTH-1]};
   assign trial   = rem_sh - {1'b0, dvsr};
   assign take    = rem_sh[WIDTH] | ~trial[WIDTH];
   assign rem_nxt = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
   assign quo_nxt = {quo[WIDTH-2:0], take};

   // Sign correction of the final iteration's outputs. The most negative
   // dividend over -1 wraps back to itself, which is the required result.
   assign rem_fix = rsign ? -rem_nxt : rem_nxt;
   assign quo_fix = qsign ? -quo_nxt : quo_nxt;

   // Next-state selection; cancel wins in every state.
   always_comb begin
      state_nxt = state;
      if (bus.cancel) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state_nxt = div_zero ? DONE : BUSY;
               end
            end
            BUSY: begin
               if (counter == LAST) begin
                  state_nxt = DONE;
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // State register; valid is registered on entry into DONE.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         valid_r <= 1'b0;
      end else begin
         state   <= state_nxt;
         valid_r <= (state_nxt == DONE);
      end
   end

   // Operand capture, iteration datapath and result register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         counter <= '0;
         rem     <= '0;
         quo     <= '0;
         dvsr    <= '0;
         qsign   <= 1'b0;
         rsign   <= 1'b0;
         hilo_r  <= '0;
      end else if (bus.cancel) begin
         counter <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  if (div_zero) begin
                     hilo_r <= {bus.a, {WIDTH{1'b1}}};
                  end else begin
                     rem     <= '0;
                     quo     <= a_mag;
                     dvsr    <= b_mag;
                     qsign   <= a_neg ^ b_neg;
                     rsign   <= a_neg;
                     counter <= '0;
                  end
               end
            end
            BUSY: begin
               rem     <= rem_nxt;
               quo     <= quo_nxt;
               counter <= counter + CW'(1);
               if (counter == LAST) begin
                  hilo_r <= {rem_fix, quo_fix};
               end
            end
            default: begin
               counter <= '0;
            end
         endcase
      end
   end

   assign bus.busy     = (state == BUSY);
   assign bus.valid    = valid_r & ~bus.cancel;
   assign bus.stall    = bus.start & ~bus.valid & ~bus.cancel;
   assign bus.hilo_out = hilo_r;
   assign state_dbg    = state;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed and randomized checks of div_unit against an
// arithmetic reference model of DIV/DIVU.
module tb_div_unit;

   localparam int         W       = 32;
   localparam logic [1:0] ST_IDLE = 2'd0;

   logic clk;
   logic resetn;
   logic [1:0] state_dbg;

   div_if #(.WIDTH(W)) bus ();

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   int n_tests = 0;
   int n_fail  = 0;
   logic [2*W-1:0] exp_q[$];
   logic [2*W-1:0] last_hilo;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain 64-bit arithmetic; remainder takes the dividend sign.
   function automatic logic [2*W-1:0] ref_div(input logic sd, input logic [W-1:0] x,
                                              input logic [W-1:0] y);
      longint sx, sy, q, r;
      if (y == '0) return {x, {W{1'b1}}};
      if (sd) begin
         sx = longint'($signed(x));
         sy = longint'($signed(y));
      end else begin
         sx = longint'({32'd0, x});
         sy = longint'({32'd0, y});
      end
      q = sx / sy;
      r = sx % sy;
      return {r[W-1:0], q[W-1:0]};
   endfunction

   // Drive one divide with start held until the valid cycle; operands are
   // scrambled after the capture cycle.
   task automatic run_div(input logic sd, input logic [W-1:0] da, input logic [W-1:0] db,
                          input string name);
      int lat;
      logic [2*W-1:0] e;
      lat = (db == '0) ? 1 : W + 1;
      exp_q.push_back(ref_div(sd, da, db));
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_div = sd; bus.a = da; bus.b = db; bus.cancel = 1'b0;
      for (int c = 0; c <= lat; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            bus.a = $urandom; bus.b = $urandom; bus.signed_div = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         n_tests++;
         if (bus.stall !== (c < lat)) begin
            n_fail++;
            $display("FAIL %s stall c=%0d: got %b want %b", name, c, bus.stall, (c < lat));
         end
         n_tests++;
         if (bus.busy !== (c >= 1 && c < lat)) begin
            n_fail++;
            $display("FAIL %s busy c=%0d: got %b", name, c, bus.busy);
         end
         n_tests++;
         if (bus.valid !== (c == lat)) begin
            n_fail++;
            $display("FAIL %s valid c=%0d: got %b want %b", name, c, bus.valid, (c == lat));
         end
      end
      e = exp_q.pop_front();
      n_tests++;
      if (bus.hilo_out !== e) begin
         n_fail++;
         $display("FAIL %s hilo: got %h want %h", name, bus.hilo_out, e);
      end
      last_hilo = e;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.valid !== 1'b0 || bus.hilo_out !== e) begin
         n_fail++;
         $display("FAIL %s after: valid %b hilo %h want 0/%h", name, bus.valid, bus.hilo_out, e);
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0; bus.signed_div = 1'b0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.stall !== 1'b0) begin
         n_fail++;
         $display("FAIL reset flags: valid %b busy %b stall %b", bus.valid, bus.busy, bus.stall);
      end
      n_tests++;
      if (bus.hilo_out !== '0 || state_dbg !== ST_IDLE) begin
         n_fail++;
         $display("FAIL reset regs: hilo %h state %0d", bus.hilo_out, state_dbg);
      end
      resetn = 1'b1;
      last_hilo = '0;
   endtask

   task automatic test_divu_basic();
      run_div(1'b0, 32'd100, 32'd7, "divu_100_7");
      n_tests++;
      if (last_hilo !== 64'h00000002_0000000E) begin
         n_fail++;
         $display("FAIL divu_100_7 model: got %h", last_hilo);
      end
   endtask

   task automatic test_signed();
      run_div(1'b1, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
      run_div(1'b1, 32'd7, 32'hFFFFFFFE, "div_7_m2");
   endtask

   task automatic test_div_zero();
      run_div(1'b0, 32'd5, 32'd0, "divu_by_zero");
      run_div(1'b1, 32'hFFFFFFF0, 32'd0, "div_by_zero");
   endtask

   task automatic test_cancel();
      logic [2*W-1:0] prev;
      prev = last_hilo;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'hFFFFFFFF; bus.b = 32'h00010000;
      for (int c = 0; c <= 11; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == 10) bus.cancel = 1'b1;
            else if (c == 11) begin bus.cancel = 1'b0; bus.start = 1'b0; end
         end
         @(negedge clk);
         n_tests++;
         if (bus.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL cancel valid c=%0d: got %b want 0", c, bus.valid);
         end
         if (c < 10) begin
            n_tests++;
            if (bus.stall !== 1'b1) begin
               n_fail++;
               $display("FAIL cancel stall c=%0d: got %b want 1", c, bus.stall);
            end
         end else if (c == 10) begin
            n_tests++;
            if (bus.stall !== 1'b0) begin
               n_fail++;
               $display("FAIL cancel stall c=10: got %b want 0", bus.stall);
            end
         end else begin
            n_tests++;
            if (state_dbg !== ST_IDLE || bus.hilo_out !== prev) begin
               n_fail++;
               $display("FAIL cancel idle: state %0d hilo %h want 0/%h", state_dbg, bus.hilo_out, prev);
            end
         end
      end
      run_div(1'b0, $urandom, 32'($urandom_range(1, 50000)), "after_cancel");
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = 32'd1000000; bus.b = 32'd7;
      for (int c = 0; c < 20; c++) begin
         if (c > 0) begin @(posedge clk); #1; end
         @(negedge clk);
         n_tests++;
         if (bus.valid !== 1'b0 || bus.busy !== (c >= 1)) begin
            n_fail++;
            $display("FAIL rstmid pre c=%0d: valid %b busy %b", c, bus.valid, bus.busy);
         end
      end
      @(posedge clk); #1;
      resetn = 1'b0;
      #1;
      n_tests++;
      if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.hilo_out !== '0 || state_dbg !== ST_IDLE) begin
         n_fail++;
         $display("FAIL rstmid async: busy %b valid %b hilo %h state %0d",
                  bus.busy, bus.valid, bus.hilo_out, state_dbg);
      end
      bus.start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      last_hilo = '0;
      run_div(1'b0, 32'd9, 32'd3, "rstmid_9_3");
      n_tests++;
      if (last_hilo !== 64'h00000000_00000003) begin
         n_fail++;
         $display("FAIL rstmid_9_3 model: got %h", last_hilo);
      end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2;
      logic [2*W-1:0] e;
      logic exp_v;
      a1 = $urandom; b1 = 32'($urandom_range(1, 1000));
      a2 = $urandom; b2 = $urandom | 32'd1;
      exp_q.push_back(ref_div(1'b0, a1, b1));
      exp_q.push_back(ref_div(1'b1, a2, b2));
      @(posedge clk); #1;
      bus.start = 1'b1; bus.signed_div = 1'b0; bus.a = a1; bus.b = b1;
      for (int c = 0; c <= 2 * (W + 1) + 1; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
            if (c == W + 2) begin
               bus.signed_div = 1'b1; bus.a = a2; bus.b = b2;
            end else begin
               bus.a = $urandom; bus.b = $urandom; bus.signed_div = 1'($urandom_range(0, 1));
            end
         end
         @(negedge clk);
         exp_v = (c == W + 1) || (c == 2 * (W + 1) + 1);
         n_tests++;
         if (bus.valid !== exp_v) begin
            n_fail++;
            $display("FAIL b2b valid c=%0d: got %b want %b", c, bus.valid, exp_v);
         end
         if (exp_v) begin
            e = exp_q.pop_front();
            n_tests++;
            if (bus.hilo_out !== e) begin
               n_fail++;
               $display("FAIL b2b hilo c=%0d: got %h want %h", c, bus.hilo_out, e);
            end
            last_hilo = e;
         end
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic test_random();
      logic [W-1:0] ra, rb;
      logic rs;
      for (int i = 0; i < 14; i++) begin
         rs = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = $urandom;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = '0;
            default: rb = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'd1;
         endcase
         run_div(rs, ra, rb, "random");
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_cancel();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage, alongside the ALU.
- Produces the 64-bit {HI, LO} = {remainder, quotient} value for the HI/LO register write path.
- Raises a stall request so the pipeline holds the divide instruction in EX until the result is ready.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.

Ports:
- clk  input  1  pipeline clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  high while a DIV/DIVU instruction sits in EX.
- signed_div  input  1  1 = DIV (two's complement), 0 = DIVU.
- a  input  WIDTH  dividend (rs).
- b  input  WIDTH  divisor (rt).
- cancel  input  1  flush from exception/ERET; aborts any operation.
- stall  output  1  combinational; = start & ~valid & ~cancel.
- busy  output  1  high in BUSY state.
- valid  output  1  one-cycle result strobe.
- hilo_out  output  2*WIDTH  {remainder, quotient}; held until the next result.

Behaviour:
- Reset (resetn low, asynchronous):
  - state=IDLE, counter=0, valid=0, busy=0, hilo_out=0.
  - All internal datapath registers are cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - If start & ~cancel & b==0: go to DONE; load quotient=all ones, remainder=a unmodified (both signed and unsigned).
  - If start & ~cancel & b!=0: capture operands.
    - Magnitudes |a| and |b| when signed_div, raw values otherwise.
    - Latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB], both gated by signed_div.
    - counter=0; go to BUSY.
- BUSY, one iteration per cycle:
  - Shift {rem, quo} left 1 bit.
  - Trial subtract rem - |b| at WIDTH+1 bits.
  - If non-negative: rem = difference, quo LSB = 1; otherwise quo LSB = 0.
  - counter++. After WIDTH iterations (counter == WIDTH-1 on the last) go to DONE.
- Entry into DONE:
  - Register hilo_out = {sign-corrected rem, sign-corrected quo}; negate (two's complement) where the latched sign is set.
  - valid=1 for exactly the DONE cycle.
  - DONE goes to IDLE unconditionally; valid returns to 0.
- Latency: start sampled in cycle 0; BUSY in cycles 1..WIDTH; valid in cycle WIDTH+1 (cycle 33 at default).
  - stall is high in cycles 0..WIDTH and low in the valid cycle so EX advances.
  - Divide-by-zero: valid in cycle 1; stall high only in cycle 0.
- Operand changes on a/b/signed_div after capture are ignored.
- Back-to-back divides: DONE always passes through one IDLE cycle.
  - A start that is still high in that IDLE cycle is a new operation.
  - A second divide therefore has its start cycle at 34.
- cancel:
  - Highest priority in every state; next state is IDLE, counter=0.
  - valid is forced 0 in the cancel cycle and the next cycle.
  - hilo_out keeps its previous value.
  - stall is 0 while cancel is high.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
  - This falls out of the magnitude datapath; no special case.
- Reset mid-operation: immediate return to IDLE with all reset values; no valid pulse.

Test Plan:
- DIVU a=100, b=7, start held -> stall high cycles 0..32; valid at cycle 33; hilo_out=0x00000002_0000000E; valid low at cycle 34.
- DIV a=0xFFFFFFF9 (-7), b=2 -> hilo_out=0xFFFFFFFF_FFFFFFFD (rem -1, quo -3).
- DIV a=0x80000000, b=0xFFFFFFFF -> hilo_out=0x00000000_80000000, after 33 cycles.
- DIVU a=5, b=0 -> valid at cycle 1, hilo_out=0x00000005_FFFFFFFF; stall high cycle 0 only.
- DIVU 0xFFFFFFFF / 0x10000 with cancel at cycle 10:
  - state IDLE at cycle 11; no valid pulse; hilo_out unchanged.
  - A new start at cycle 12 completes with valid at cycle 45.
- resetn pulsed low at cycle 20 mid-divide -> outputs 0 immediately (asynchronously).
  - After release, DIVU 9/3 gives hilo_out=0x00000000_00000003.
